// File: rtl/bsg_credit_rr_arbiter.sv
// Credit-gated round-robin arbiter: grants one requester per cycle while the
// downstream credit pool is non-empty; returned credits saturate with a sticky overflow flag.
module bsg_credit_rr_arbiter #(
   parameter int unsigned els_p          = 4,
   parameter int unsigned max_credits_p  = 9,
   parameter int unsigned init_credits_p = 9
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [els_p-1:0]           reqs_i,
   input  logic                       ready_i,
   input  logic                       credit_i,
   output logic [els_p-1:0]           grants_o,
   output logic [$clog2(els_p)-1:0]   tag_o,
   output logic                       v_o,
   output logic [3:0]                 credits_o,
   output logic                       overflow_o
);

   localparam int unsigned tag_width_lp = $clog2(els_p);

   logic [tag_width_lp-1:0] ptr_r;
   logic [tag_width_lp-1:0] sel;
   logic [tag_width_lp-1:0] cand;
   logic                    hit;
   logic [3:0]              credits_r;
   logic                    overflow_r;
   logic                    transfer;

   // Scan from the pointer upward, wrapping, and keep the first asserted request.
   always_comb begin
      int unsigned idx;
      idx  = 0;
      cand = '0;
      sel  = '0;
      hit  = 1'b0;
      for (int unsigned i = 0; i < els_p; i++) begin
         idx = 32'(ptr_r) + i;
         if (idx >= els_p) idx = idx - els_p;
         cand = tag_width_lp'(idx);
         if (!hit && reqs_i[cand]) begin
            hit = 1'b1;
            sel = cand;
         end
      end
   end

   // Grants depend only on the registered count, so a same-cycle credit cannot unblock them.
   assign v_o      = ~reset_i & hit & (credits_r != 4'd0);
   assign tag_o    = v_o ? sel : '0;
   assign transfer = v_o & ready_i;

   always_comb begin
      grants_o = '0;
      if (v_o) grants_o[sel] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_r      <= '0;
         credits_r  <= 4'(init_credits_p);
         overflow_r <= 1'b0;
      end else begin
         if (transfer)
            ptr_r <= (32'(sel) == els_p - 1) ? '0 : sel + 1'b1;
         if (credit_i && !transfer && credits_r == 4'(max_credits_p))
            overflow_r <= 1'b1;
         else
            credits_r <= credits_r - {3'b000, transfer} + {3'b000, credit_i};
      end
   end

   assign credits_o  = credits_r;
   assign overflow_o = overflow_r;

endmodule

// File: doc/bsg_credit_rr_arbiter.md
BSG_CREDIT_RR_ARBITER -- requirements
Module: bsg_credit_rr_arbiter

Interface
REQ-001 Parameter els_p, default 4: number of requesters, range 2..16.
REQ-002 Parameter max_credits_p, default 9: credit pool capacity, range 1..15.
REQ-003 Parameter init_credits_p, default 9: credit count loaded at reset, range 0..max_credits_p.
REQ-004 clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1: synchronous, active-high reset.
REQ-006 reqs_i  input  els_p: per-requester valid; held by the requester until granted with ready_i.
REQ-007 ready_i  input  1: downstream accepts the granted item this cycle.
REQ-008 credit_i  input  1: one credit returned from downstream this cycle.
REQ-009 grants_o  output  els_p: one-hot grant; all zeros when v_o=0.
REQ-010 tag_o  output  clog2(els_p): index of the granted requester; 0 when v_o=0.
REQ-011 v_o  output  1: a grant is offered this cycle.
REQ-012 credits_o  output  4: current credit count, registered.
REQ-013 overflow_o  output  1: sticky flag; a credit was returned while the pool was full.

Function
REQ-014 v_o SHALL equal (|reqs_i) AND (credits_o != 0); combinational from inputs and registered state.
REQ-015 A grant SHALL be issued only from the registered count; a credit_i in the same cycle SHALL NOT enable a grant when credits_o=0.
REQ-016 Arbitration: round-robin over a priority pointer ptr_r (clog2(els_p) bits). The granted index SHALL be the first asserted reqs_i bit at or after ptr_r, wrapping from els_p-1 to 0.
REQ-017 A transfer occurs when v_o AND ready_i are both 1. The requester at tag_o SHALL treat grants_o[tag_o] AND ready_i as consume.
REQ-018 On a transfer, ptr_r SHALL advance to tag_o+1 modulo els_p on the next edge; otherwise ptr_r SHALL hold.
REQ-019 grants_o and tag_o SHALL be stable while reqs_i, ptr_r and credits_o are unchanged, including when ready_i=0.
REQ-020 Credit next-state: count_next = count - transfer + credit_i, computed at 4-bit width.
REQ-021 A simultaneous transfer and credit_i SHALL leave the count unchanged.
REQ-022 If credit_i=1, no transfer occurs, and count=max_credits_p, the count SHALL saturate at max_credits_p and overflow_o SHALL set on the next edge.
REQ-023 Underflow SHALL be impossible by construction, because a transfer requires count>0.
REQ-024 overflow_o SHALL remain set until reset.
REQ-025 Zero-latency grant: a request presented with credits available and ready_i=1 transfers in the same cycle.

Reset
REQ-026 While reset_i=1 at an edge: credits_o=init_credits_p, ptr_r=0, overflow_o=0.
REQ-027 During reset, transfers and credit_i SHALL be ignored in the next-state computation.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight count and pointer with no partial update.
REQ-029 Outputs SHALL be combinationally gated: v_o and grants_o SHALL be 0 while reset_i=1.

Verification
REQ-030 Reset with defaults, reqs_i=4'b1111, ready_i=1, no credit_i -> grants cycle through 0,1,2,3,0,... for 9 cycles, credits_o 9->0, then v_o=0.
REQ-031 credits_o=0, reqs_i=4'b0100, credit_i=1 in cycle t -> v_o=0 in cycle t; credits_o=1 and grants_o=4'b0100 in cycle t+1.
REQ-032 credits_o=5, sustained transfer with credit_i=1 each cycle for 10 cycles -> credits_o stays 5, and round-robin order is preserved.
REQ-033 credits_o=9, credit_i=1, reqs_i=0 -> credits_o stays 9, overflow_o=1 next cycle and persists until reset_i.
REQ-034 reqs_i=4'b1001, ptr_r=1, ready_i=0 for 3 cycles then 1 -> tag_o=3 held for all 4 cycles; after the transfer ptr_r=0 and the next grant goes to 0.
REQ-035 Reset asserted with credits_o=2 and ptr_r=3 during active transfers -> next cycle credits_o=9, ptr_r=0, overflow_o=0, and no transfer is counted.
